// File: rtl/motor602_deadtime.sv
// rtl/motor602_deadtime.sv - three-phase gate interlock with dead-time insertion and conflict fault latching
module motor602_deadtime #(
    parameter int DEAD_CYCLES = 50,
    parameter int CNT_W       = 10
) (
    input  logic       clk50mhzI,
    input  logic       nResetI,
    input  logic [2:0] hiReqI,
    input  logic [2:0] loReqI,
    input  logic       forceStopI,
    input  logic       clrFaultI,
    output logic       aHPo,
    output logic       aLNo,
    output logic       bHPo,
    output logic       bLNo,
    output logic       cHPo,
    output logic       cLNo,
    output logic [2:0] faultO,
    output logic [2:0] busyO
);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_HI   = 2'd2,
        ST_LO   = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DEAD_CYCLES - 1);

    state_e           state_q [3];
    state_e           state_d [3];
    logic [CNT_W-1:0] cnt_q   [3];
    logic [CNT_W-1:0] cnt_d   [3];
    logic [2:0]       fault_q;
    logic [2:0]       fault_d;
    logic [2:0]       hi_req;
    logic [2:0]       lo_req;

    // A simultaneous high and low request cancels out to "no request".
    assign hi_req = hiReqI & ~loReqI & {3{~forceStopI}};
    assign lo_req = loReqI & ~hiReqI & {3{~forceStopI}};

    always_comb begin
        fault_d = (hiReqI & loReqI) | (fault_q & {3{~clrFaultI}});
        for (int p = 0; p < 3; p++) begin
            state_d[p] = state_q[p];
            cnt_d[p]   = cnt_q[p];
            case (state_q[p])
                ST_IDLE: begin
                    if (hi_req[p])      state_d[p] = ST_HI;
                    else if (lo_req[p]) state_d[p] = ST_LO;
                end
                ST_HI: begin
                    if (!hi_req[p]) begin
                        state_d[p] = ST_WAIT;
                        cnt_d[p]   = RELOAD;
                    end
                end
                ST_LO: begin
                    if (!lo_req[p]) begin
                        state_d[p] = ST_WAIT;
                        cnt_d[p]   = RELOAD;
                    end
                end
                default: begin
                    // Force stop holds the dead time at its full length.
                    if (cnt_q[p] != '0) begin
                        cnt_d[p] = forceStopI ? RELOAD : cnt_q[p] - CNT_W'(1);
                    end else if (hi_req[p]) begin
                        state_d[p] = ST_HI;
                    end else if (lo_req[p]) begin
                        state_d[p] = ST_LO;
                    end else begin
                        state_d[p] = ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk50mhzI or negedge nResetI) begin
        if (!nResetI) begin
            for (int p = 0; p < 3; p++) begin
                state_q[p] <= ST_WAIT;
                cnt_q[p]   <= RELOAD;
            end
            fault_q <= 3'b000;
        end else begin
            for (int p = 0; p < 3; p++) begin
                state_q[p] <= state_d[p];
                cnt_q[p]   <= cnt_d[p];
            end
            fault_q <= fault_d;
        end
    end

    // Gates decode from the state register only, so reset turns them off at once.
    assign aHPo = (state_q[0] != ST_HI);
    assign bHPo = (state_q[1] != ST_HI);
    assign cHPo = (state_q[2] != ST_HI);
    assign aLNo = (state_q[0] == ST_LO);
    assign bLNo = (state_q[1] == ST_LO);
    assign cLNo = (state_q[2] == ST_LO);

    assign busyO[0] = (state_q[0] == ST_WAIT);
    assign busyO[1] = (state_q[1] == ST_WAIT);
    assign busyO[2] = (state_q[2] == ST_WAIT);
    assign faultO   = fault_q;

endmodule

// File: tb/tb_motor602_deadtime.sv
// tb/tb_motor602_deadtime.sv - directed scoreboard bench plus random interlock stress for motor602_deadtime
module tb_motor602_deadtime;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] hi_req, lo_req;
    logic       force_stop, clr_fault;
    logic       a_hp, a_ln, b_hp, b_ln, c_hp, c_ln;
    logic [2:0] fault, busy;

    logic       s_rst_n;
    logic [2:0] s_hi, s_lo;
    logic       s_force, s_clr;
    logic [2:0] s_hp, s_ln, s_fault, s_busy;

    int n_total = 0;
    int n_pass  = 0;

    logic [11:0] exp_q [$];
    string       tag_q [$];
    logic [11:0] obs;

    // Layout: fault[2:0] busy[2:0] cLN cHP bLN bHP aLN aHP
    localparam logic [11:0] V_RESET  = 12'b000_111_010101;
    localparam logic [11:0] V_A_HI   = 12'b000_000_010100;
    localparam logic [11:0] V_A_WAIT = 12'b000_001_010101;
    localparam logic [11:0] V_A_LO   = 12'b000_000_010111;
    localparam logic [11:0] V_B_FLT  = 12'b010_000_010111;
    localparam logic [11:0] V_ALL_ON = 12'b000_000_000011;
    localparam logic [11:0] V_C_LO   = 12'b000_000_110101;

    assign obs = {fault, busy, c_ln, c_hp, b_ln, b_hp, a_ln, a_hp};

    always #10 clk = ~clk;

    motor602_deadtime u_dut (
        .clk50mhzI (clk),
        .nResetI   (rst_n),
        .hiReqI    (hi_req),
        .loReqI    (lo_req),
        .forceStopI(force_stop),
        .clrFaultI (clr_fault),
        .aHPo      (a_hp),
        .aLNo      (a_ln),
        .bHPo      (b_hp),
        .bLNo      (b_ln),
        .cHPo      (c_hp),
        .cLNo      (c_ln),
        .faultO    (fault),
        .busyO     (busy)
    );

    motor602_deadtime #(.DEAD_CYCLES(2), .CNT_W(2)) u_stress (
        .clk50mhzI (clk),
        .nResetI   (s_rst_n),
        .hiReqI    (s_hi),
        .loReqI    (s_lo),
        .forceStopI(s_force),
        .clrFaultI (s_clr),
        .aHPo      (s_hp[0]),
        .aLNo      (s_ln[0]),
        .bHPo      (s_hp[1]),
        .bLNo      (s_ln[1]),
        .cHPo      (s_hp[2]),
        .cLNo      (s_ln[2]),
        .faultO    (s_fault),
        .busyO     (s_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pop();
        logic [11:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_total++;
        assert (obs === e) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", t, obs, e);
    endtask

    task automatic expect_now(input string tag, input logic [11:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        check_pop();
    endtask

    task automatic expect_tick(input string tag, input logic [11:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        tick();
        check_pop();
    endtask

    task automatic expect_ticks(input string tag, input int n, input logic [11:0] e);
        for (int i = 0; i < n; i++) expect_tick(tag, e);
    endtask

    initial begin
        int  off_cnt [3];
        bit  seen_on [3];
        bit  was_on  [3];
        bit  last_hi [3];
        bit  on, side_hi;

        rst_n = 1'b0; hi_req = 3'b001; lo_req = 3'b000; force_stop = 1'b0; clr_fault = 1'b0;
        s_rst_n = 1'b0; s_hi = '0; s_lo = '0; s_force = 1'b0; s_clr = 1'b0;
        #3;
        expect_now("reset_state", V_RESET);

        // Power-up: request already present, dead time must still elapse.
        @(posedge clk); #2 rst_n = 1'b1;
        expect_ticks("powerup_hold", 49, V_RESET);
        expect_tick("powerup_on", V_A_HI);

        // Switch-over from high side to low side on phase a.
        hi_req = 3'b000; lo_req = 3'b001;
        expect_tick("switch_off", V_A_WAIT);
        expect_ticks("switch_dead", 49, V_A_WAIT);
        expect_tick("switch_lo_on", V_A_LO);

        // Conflict on phase b.
        hi_req = 3'b010; lo_req = 3'b011;
        expect_ticks("conflict_hold", 3, V_B_FLT);
        hi_req = 3'b000; lo_req = 3'b001; clr_fault = 1'b1;
        expect_tick("fault_clear", V_A_LO);
        hi_req = 3'b010; lo_req = 3'b011;
        expect_tick("fault_set_wins", V_B_FLT);
        clr_fault = 1'b0;
        expect_tick("fault_sticky", V_B_FLT);
        hi_req = 3'b000; lo_req = 3'b001; clr_fault = 1'b1;
        expect_tick("fault_clear2", V_A_LO);
        clr_fault = 1'b0;

        // Force stop with all three phases on.
        hi_req = 3'b110; lo_req = 3'b001;
        expect_tick("all_on", V_ALL_ON);
        force_stop = 1'b1;
        expect_tick("force_off", V_RESET);
        expect_ticks("force_hold", 199, V_RESET);
        force_stop = 1'b0;
        expect_ticks("force_dead", 49, V_RESET);
        expect_tick("force_resume", V_ALL_ON);

        // Bring phase c to the low side, then reset asynchronously mid-cycle.
        hi_req = 3'b000; lo_req = 3'b100;
        expect_tick("c_switch_off", V_RESET);
        expect_ticks("c_switch_dead", 49, V_RESET);
        expect_tick("c_lo_on", V_C_LO);
        #2 rst_n = 1'b0;
        #1;
        expect_now("async_reset_off", V_RESET);
        @(posedge clk); #2 rst_n = 1'b1;
        expect_ticks("post_reset_dead", 49, V_RESET);
        expect_tick("post_reset_on", V_C_LO);

        // Random stress on the short dead-time instance.
        for (int p = 0; p < 3; p++) begin
            off_cnt[p] = 0; seen_on[p] = 1'b0; was_on[p] = 1'b0; last_hi[p] = 1'b0;
        end
        @(posedge clk); #2 s_rst_n = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) s_hi = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) s_lo = 3'($urandom_range(0, 7));
            s_force = ($urandom_range(0, 19) == 0);
            s_clr   = ($urandom_range(0, 7) == 0);
            tick();
            for (int p = 0; p < 3; p++) begin
                n_total++;
                assert (!(s_hp[p] == 1'b0 && s_ln[p] == 1'b1)) n_pass++;
                else $error("FAIL stress_shoot_through phase=%0d hp=%b ln=%b required=not both on", p, s_hp[p], s_ln[p]);
                on      = (s_hp[p] == 1'b0) || (s_ln[p] == 1'b1);
                side_hi = (s_hp[p] == 1'b0);
                if (on && seen_on[p] && (!was_on[p] || side_hi != last_hi[p])) begin
                    n_total++;
                    assert (off_cnt[p] >= 2) n_pass++;
                    else $error("FAIL stress_dead_time phase=%0d off_cycles=%0d required>=2", p, off_cnt[p]);
                end
                if (on) begin
                    off_cnt[p] = 0; seen_on[p] = 1'b1; last_hi[p] = side_hi;
                end else begin
                    off_cnt[p]++;
                end
                was_on[p] = on;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
